// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings for the instruction fetch unit.
// Holds the next-PC operation codes and the run/halt/fault state type.
package ifu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_npc.sv
// npc: combinational next-PC target computation for the fetch unit.
// Produces the candidate target for the current npc_op and flags targets
// that are misaligned or fall outside the instruction-memory window that
// contains RESET_PC.
module npc
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] target,
  output logic        illegal
);

  // Bits above the fetch window must match RESET_PC for a target to be legal.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (IM_AW + 2)) - 32'd1);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign seq_pc = pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the next PC candidate; all sums wrap modulo 2^32.
  always_comb begin
    target = seq_pc;
    case (npc_op)
      NPC_SEQ: target = seq_pc;
      NPC_BR:  target = br_taken ? (seq_pc + br_off) : seq_pc;
      NPC_J:   target = {seq_pc[31:28], imm26, 2'b00};
      NPC_JR:  target = rs_val;
      default: target = seq_pc;
    endcase
  end

  // Misalignment or leaving the memory window makes the target illegal.
  always_comb begin
    illegal = (target[1:0] != 2'b00) || (((target ^ RESET_PC) & HI_MASK) != 32'd0);
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit holding the PC, its run/halt/fault FSM and,
// when IFU_FETCH_CNT_EN is defined, a retired-fetch counter.
// Optional feature macro: IFU_FETCH_CNT_EN (adds the fetch_cnt port).
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       npc_op,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      rs_val,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [IM_AW-1:0] im_addr,
  output logic             halted,
  output logic             addr_err
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0]      fetch_cnt
`endif
);

  ifu_state_t  state;
  logic [31:0] target;
  logic        illegal;
  logic        pc_update;

  npc #(
    .RESET_PC (RESET_PC),
    .IM_AW    (IM_AW)
  ) u_npc (
    .pc       (pc),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .target   (target),
    .illegal  (illegal)
  );

  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = pc[IM_AW+1:2];

  // The PC only advances in RUN when enabled, not halting, and legal.
  always_comb begin
    pc_update = (state == RUN) && !halt_req && en && !illegal;
  end

  // PC register and run/halt/fault FSM; halt outranks a fault, HALT and FAULT
  // are sticky until reset, and the status flags are registered decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= RUN;
      halted   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (en && illegal) begin
            state    <= FAULT;
            addr_err <= 1'b1;
          end else if (en) begin
            pc <= target;
          end
        end
        HALT: begin
          state <= HALT;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state    <= FAULT;
          halted   <= 1'b0;
          addr_err <= 1'b1;
        end
      endcase
    end
  end

`ifdef IFU_FETCH_CNT_EN
  // Count every edge on which the PC actually advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
    end else if (pc_update) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule
